// File: rtl/cu_pkg.sv
// Shared types for the CU instruction fetch stage: FSM states, buffer entry layout
// and the PC legality test used for both sequential and redirect targets.
package cu_pkg;

  localparam int unsigned IMEM_WORDS_DEF = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  // Word aligned and inside the instruction memory; 34-bit compare so no wrap can hide a bad PC.
  function automatic logic pc_legal(input logic [31:0] pc, input int unsigned words);
    logic [33:0] limit;
    limit = 34'(words) << 2;
    return (pc[1:0] == 2'b00) && ({2'b00, pc} < limit);
  endfunction

endpackage

// File: rtl/cu_if_fetch_if.sv
// Fetch-stage bus bundle: instruction memory read port, decode handshake and CU redirect.
interface cu_if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_ir, if_pc, if_pc_plus4,
    input  imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_ir, if_pc, if_pc_plus4,
    output imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cu_if_buffer.sv
// Small power-of-two FIFO of fetched {pc, ir} entries with flush; only pointers and
// count are reset, the storage is qualified by the count.
module cu_if_buffer
  import cu_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                       soc_clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(BUF_DEPTH):0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(BUF_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge soc_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cu_if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one imem read at a time, buffers
// returned words for decode, handles CU redirects and latches a sticky fetch error.
module cu_if_fetch
  import cu_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic          soc_clk,
  input  logic          reset,
  input  logic          fetch_en,
  cu_if_fetch_if.master bus,
  output logic          fetch_err,
  output logic [31:0]   err_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic             drop, drop_nxt;
  logic             err_nxt;
  logic [31:0]      err_pc_nxt;
  logic             push, pop, flush;
  logic             outstanding, room;
  logic [CNT_W:0]   in_use;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic [CNT_W-1:0] buf_count;
  logic             buf_empty, buf_full;

  cu_if_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .soc_clk   (soc_clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // Counting the in-flight word keeps the buffer from ever overflowing on its return.
  assign outstanding = (state == REQ) || (state == WAIT);
  assign in_use      = {1'b0, buf_count} + (CNT_W + 1)'(outstanding);
  assign room        = !buf_full && (in_use < (CNT_W + 1)'(BUF_DEPTH));
  assign push_data   = '{pc: pc, ir: bus.imem_rdata};

  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      fetch_err <= 1'b0;
      err_pc    <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop      <= drop_nxt;
      fetch_err <= err_nxt;
      err_pc    <= err_pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    drop_nxt   = drop;
    err_nxt    = fetch_err;
    err_pc_nxt = err_pc;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_valid) begin
      // Redirect wins over everything this edge: no push, no pop, buffered work is stale.
      flush = 1'b1;
      if (state != HALT) begin
        if (!pc_legal(bus.redirect_pc, IMEM_WORDS)) begin
          err_nxt    = 1'b1;
          err_pc_nxt = bus.redirect_pc;
          state_nxt  = HALT;
          drop_nxt   = 1'b0;
        end else begin
          pc_nxt = bus.redirect_pc;
          case (state)
            REQ: begin
              state_nxt = WAIT;
              drop_nxt  = 1'b1;
            end
            WAIT: begin
              state_nxt = bus.imem_rvalid ? IDLE : WAIT;
              drop_nxt  = !bus.imem_rvalid;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
    end else begin
      pop = !buf_empty && bus.id_ready;
      case (state)
        IDLE: begin
          if (fetch_en && !fetch_err && room) begin
            if (pc_legal(pc, IMEM_WORDS)) begin
              state_nxt = REQ;
            end else begin
              err_nxt    = 1'b1;
              err_pc_nxt = pc;
              state_nxt  = HALT;
            end
          end
        end
        REQ: state_nxt = WAIT;
        WAIT: begin
          if (bus.imem_rvalid) begin
            state_nxt = IDLE;
            if (drop) begin
              drop_nxt = 1'b0;
            end else begin
              push   = 1'b1;
              pc_nxt = pc + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = (state == REQ) ? pc : '0;
  assign bus.if_valid    = !buf_empty;
  assign bus.if_ir       = buf_empty ? '0 : head.ir;
  assign bus.if_pc       = buf_empty ? '0 : head.pc;
  assign bus.if_pc_plus4 = buf_empty ? '0 : head.pc + 32'd4;

endmodule

// File: tb/tb_cu_if_fetch.sv
// Bench for cu_if_fetch: directed scenarios plus a randomized phase, with decode-side
// delivery checked against an in-order instruction stream model.
module tb_cu_if_fetch;

  logic        soc_clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        fetch_err, fetch_err5;
  logic [31:0] err_pc, err_pc5;

  cu_if_fetch_if bus ();
  cu_if_fetch_if b5 ();

  always #5 soc_clk = ~soc_clk;

  cu_if_fetch #(.IMEM_WORDS(128), .RESET_PC(32'h0), .BUF_DEPTH(2)) u_dut (
    .soc_clk(soc_clk), .reset(reset), .fetch_en(fetch_en), .bus(bus),
    .fetch_err(fetch_err), .err_pc(err_pc));

  cu_if_fetch #(.IMEM_WORDS(128), .RESET_PC(32'h1F8), .BUF_DEPTH(2)) u_dut5 (
    .soc_clk(soc_clk), .reset(reset), .fetch_en(fetch_en), .bus(b5),
    .fetch_err(fetch_err5), .err_pc(err_pc5));

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [128];
  logic [31:0] exp_pc;
  int          delivered;
  bit          halted;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat;
  bit          rand_lat;
  bit          req_now;
  logic [31:0] req_addr;
  int          reqs;
  bit          pend5;
  logic [31:0] pend5_addr;
  int          reqs5;
  logic [31:0] q5_pc[$];
  logic [31:0] q5_ir[$];
  bit          found;
  int          n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: score the decode handoff about to happen, run the memory models, advance.
  task automatic cycle();
    req_now  = bus.imem_req;
    req_addr = bus.imem_addr;
    if (halted) chk1("halt_no_req", bus.imem_req, 1'b0);
    if (bus.redirect_valid) begin
      if (!halted) begin
        if (bus.redirect_pc % 4 == 0 && bus.redirect_pc < 32'd512) exp_pc = bus.redirect_pc;
        else halted = 1'b1;
      end
    end else if (bus.if_valid && bus.id_ready) begin
      chk("pop_pc", bus.if_pc, exp_pc);
      chk("pop_ir", bus.if_ir, mem[exp_pc[8:2]]);
      chk("pop_pc_plus4", bus.if_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom();
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem[pend_addr[8:2]];
        pend = 1'b0;
      end
    end
    if (req_now) begin
      pend      = 1'b1;
      pend_addr = req_addr;
      pend_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      reqs++;
    end
    if (b5.if_valid) begin
      q5_pc.push_back(b5.if_pc);
      q5_ir.push_back(b5.if_ir);
    end
    b5.imem_rvalid = pend5;
    b5.imem_rdata  = mem[pend5_addr[8:2]];
    pend5 = 1'b0;
    if (b5.imem_req) begin
      pend5      = 1'b1;
      pend5_addr = b5.imem_addr;
      reqs5++;
    end
    @(posedge soc_clk);
    @(negedge soc_clk);
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    fetch_en           = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b0;
    b5.imem_rvalid     = 1'b0;
    pend               = 1'b0;
    pend5              = 1'b0;
    @(posedge soc_clk);
    @(negedge soc_clk);
    reset     = 1'b1;
    exp_pc    = 32'h0;
    halted    = 1'b0;
    delivered = 0;
    reqs      = 0;
    reqs5     = 0;
    q5_pc.delete();
    q5_ir.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_req"}, bus.imem_req, 1'b0);
    chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    chk1({tag, "_valid"}, bus.if_valid, 1'b0);
    chk({tag, "_ir"}, bus.if_ir, 32'h0);
    chk({tag, "_pc"}, bus.if_pc, 32'h0);
    chk({tag, "_pc4"}, bus.if_pc_plus4, 32'h0);
    chk1({tag, "_err"}, fetch_err, 1'b0);
    chk({tag, "_errpc"}, err_pc, 32'h0);
  endtask

  initial begin
    reset = 1'b0; fetch_en = 1'b0;
    bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    b5.id_ready = 1'b1; b5.redirect_valid = 1'b0; b5.redirect_pc = '0;
    b5.imem_rvalid = 1'b0; b5.imem_rdata = '0;
    lat = 1; rand_lat = 1'b0; pend = 1'b0; pend_addr = '0; pend_cnt = 0;
    pend5 = 1'b0; pend5_addr = '0; exp_pc = '0; halted = 1'b0;
    delivered = 0; reqs = 0; reqs5 = 0; req_now = 1'b0; req_addr = '0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom();

    @(negedge soc_clk);
    chk_all_zero("reset");
    do_reset();

    // Streaming fetch with single-cycle memory and decode always ready
    bus.id_ready = 1'b1;
    fetch_en     = 1'b1;
    cycle();
    chk1("t1_first_req", bus.imem_req, 1'b1);
    chk("t1_first_addr", bus.imem_addr, 32'h0);
    cycle();
    cycle();
    chk1("t1_first_valid", bus.if_valid, 1'b1);
    chk("t1_first_pc", bus.if_pc, 32'h0);
    repeat (30) cycle();
    chk1("t1_throughput", delivered >= 9, 1'b1);

    // Decode stalled: exactly two words buffered, then drained in order
    do_reset();
    fetch_en     = 1'b1;
    bus.id_ready = 1'b0;
    repeat (10) cycle();
    chk("t2_reqs", 32'(reqs), 32'd2);
    chk1("t2_valid", bus.if_valid, 1'b1);
    chk("t2_head_pc", bus.if_pc, 32'h0);
    chk1("t2_no_third_req", bus.imem_req, 1'b0);
    bus.id_ready = 1'b1;
    repeat (20) cycle();
    chk1("t2_drained", delivered >= 4, 1'b1);

    // Redirect while the word for 0x8 is outstanding with latency 3
    do_reset();
    lat = 3; fetch_en = 1'b1; bus.id_ready = 1'b1; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (req_now && req_addr == 32'h8) found = 1'b1;
    end
    chk1("t3_req8_seen", found, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    cycle();
    bus.redirect_valid = 1'b0;
    chk1("t3_flushed", bus.if_valid, 1'b0);
    n = delivered; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (req_now) found = 1'b1;
    end
    chk1("t3_req_after_redirect", found, 1'b1);
    chk("t3_req_addr", req_addr, 32'h40);
    repeat (12) cycle();
    chk1("t3_delivered_target", delivered > n, 1'b1);

    // Randomized traffic: latency, stalls, fetch_en drops and legal redirects
    rand_lat = 1'b1; n = delivered;
    for (int i = 0; i < 300; i++) begin
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      fetch_en           = ($urandom_range(0, 15) != 0);
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_pc    = 32'($urandom_range(0, 64)) * 32'd4;
      cycle();
    end
    bus.redirect_valid = 1'b0;
    rand_lat = 1'b0;
    chk1("rand_progress", delivered > n + 20, 1'b1);

    // Misaligned and out-of-range redirect targets
    do_reset();
    lat = 1; fetch_en = 1'b1; bus.id_ready = 1'b1;
    repeat (5) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    cycle();
    bus.redirect_valid = 1'b0;
    chk1("t4a_err", fetch_err, 1'b1);
    chk("t4a_err_pc", err_pc, 32'h42);
    chk1("t4a_flushed", bus.if_valid, 1'b0);
    n = reqs;
    repeat (10) cycle();
    chk("t4a_no_req", 32'(reqs), 32'(n));
    do_reset();
    fetch_en = 1'b1; bus.id_ready = 1'b1;
    repeat (2) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    cycle();
    bus.redirect_valid = 1'b0;
    chk1("t4b_err", fetch_err, 1'b1);
    chk("t4b_err_pc", err_pc, 32'h200);
    n = reqs;
    repeat (10) cycle();
    chk("t4b_no_req", 32'(reqs), 32'(n));

    // Sequential run off the end of memory on the second instance
    do_reset();
    fetch_en = 1'b1; bus.id_ready = 1'b1;
    repeat (20) cycle();
    chk("t5_reqs", 32'(reqs5), 32'd2);
    chk("t5_delivered", 32'(q5_pc.size()), 32'd2);
    for (int i = 0; i < q5_pc.size() && i < 2; i++) begin
      chk("t5_pc", q5_pc[i], 32'h1F8 + 32'(4 * i));
      chk("t5_ir", q5_ir[i], mem[7'd126 + 7'(i)]);
    end
    chk1("t5_err", fetch_err5, 1'b1);
    chk("t5_err_pc", err_pc5, 32'h200);

    // Reset during WAIT; the late response must be ignored
    do_reset();
    lat = 5; fetch_en = 1'b1; bus.id_ready = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (req_now) found = 1'b1;
    end
    chk1("t6_req_seen", found, 1'b1);
    fetch_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    cycle();
    reset = 1'b1; exp_pc = 32'h0; halted = 1'b0; delivered = 0; reqs = 0;
    repeat (6) cycle();
    chk1("t6_stale_ignored", bus.if_valid, 1'b0);
    chk("t6_no_req_while_off", 32'(reqs), 32'd0);
    fetch_en = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (req_now) found = 1'b1;
    end
    chk1("t6_restart_req", found, 1'b1);
    chk("t6_restart_addr", req_addr, 32'h0);
    repeat (10) cycle();
    chk1("t6_restart_delivered", delivered >= 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
